// File: rtl/press_pulse_gen.sv
// press_pulse_gen: turns single-cycle request strobes into timed button presses with a queued backlog.
// Define PRESS_PULSE_GEN_COUNT_EN to add the o_press_count completed-press counter.
module press_pulse_gen #(
    parameter int CNT_W  = 32,
    parameter int PEND_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_pulse,
    input  logic [CNT_W-1:0]  i_hold_cycles,
    input  logic [CNT_W-1:0]  i_gap_cycles,
    output logic              o_button,
    output logic              o_busy,
    output logic [PEND_W-1:0] o_pending,
    output logic              o_overflow
`ifdef PRESS_PULSE_GEN_COUNT_EN
    ,
    output logic [15:0]       o_press_count
`endif
);
    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;
    state_t state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d, hold_m1, gap_m1;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic button_q, busy_q, ovf_q, ovf_d;
    logic tz, hold_end, gap_end, start, enq, deq, full;
    // The timer holds the remaining cycles minus one, so a zero duration collapses to one cycle.
    always_comb begin
        hold_m1  = (i_hold_cycles == '0) ? '0 : i_hold_cycles - CNT_W'(1);
        gap_m1   = (i_gap_cycles == '0) ? '0 : i_gap_cycles - CNT_W'(1);
        tz       = (timer_q == '0);
        full     = (pend_q == '1);
        hold_end = (state_q == HOLD) && tz;
        gap_end  = (state_q == GAP) && tz;
        start    = ((state_q == IDLE) && i_pulse) || (gap_end && (i_pulse || (pend_q != '0)));
        enq      = i_pulse && (state_q != IDLE) && !gap_end;
        deq      = gap_end && (pend_q != '0) && !i_pulse;
        pend_d   = (enq && !full) ? pend_q + PEND_W'(1) : deq ? pend_q - PEND_W'(1) : pend_q;
        ovf_d    = enq && full;
        state_d  = start ? HOLD : hold_end ? GAP : gap_end ? IDLE : state_q;
        timer_d  = start ? hold_m1 : hold_end ? gap_m1 : tz ? timer_q : timer_q - CNT_W'(1);
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            pend_q   <= '0;
            button_q <= 1'b0;
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            pend_q   <= pend_d;
            button_q <= (state_d == HOLD);
            busy_q   <= (state_d != IDLE);
            ovf_q    <= ovf_d;
        end
    end
`ifdef PRESS_PULSE_GEN_COUNT_EN
    logic [15:0] count_q;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            count_q <= '0;
        else if (hold_end)
            count_q <= count_q + 16'd1;
    end
    assign o_press_count = count_q;
`endif
    assign o_button   = button_q;
    assign o_busy     = busy_q;
    assign o_pending  = pend_q;
    assign o_overflow = ovf_q;
endmodule
